// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: syncs receiver strobes into sysclk, buffers a write burst in a
// shadow bank and commits it atomically to the live fan-control registers on CS release.
module spi_reg_ctrl #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [7:0]  RESET_VAL = 8'h80
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  iRxReady,
  input  logic [7:0]            iRx,
  input  logic                  iSPICS,
  output logic [8*NUM_REGS-1:0] oRegs,
  output logic                  oUpdate,
  output logic                  oFrameErr,
  output logic [7:0]            oErrCount,
  output logic [7:0]            probe
);

  localparam int unsigned PTR_W  = 4;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef logic [NUM_REGS-1:0][7:0] bank_t;

  state_e            state_q, state_d;
  bank_t             regs_q, regs_d;
  bank_t             shadow_q, shadow_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wrote_q, wrote_d;
  logic              err_q, err_d;
  logic              upd_q, upd_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        errcnt_q, errcnt_d;
  logic [SYNC_W-1:0] rdy_sync_q, rdy_sync_d;
  logic [SYNC_W-1:0] cs_sync_q, cs_sync_d;

  logic strobe, cs_fall, cs_rise, cmd_ok, drop;

  // Two synchroniser stages plus one history stage per asynchronous input
  assign rdy_sync_d = {rdy_sync_q[SYNC_W-2:0], iRxReady};
  assign cs_sync_d  = {cs_sync_q[SYNC_W-2:0], iSPICS};

  assign strobe  = rdy_sync_q[1] & ~rdy_sync_q[2];
  assign cs_fall = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise = cs_sync_q[1] & ~cs_sync_q[2];
  assign cmd_ok  = (iRx[7:6] == 2'b10) && ({1'b0, iRx[5:0]} < 7'(NUM_REGS));

  // Frame parser: strobe is applied first, then a same-cycle CS release closes the frame
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    shadow_d = shadow_q;
    ptr_d    = ptr_q;
    wrote_d  = wrote_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    upd_d    = 1'b0;
    ferr_d   = 1'b0;
    drop     = 1'b0;

    if (cs_fall) begin
      drop     = (state_q != IDLE);
      state_d  = CMD;
      shadow_d = regs_q;
      ptr_d    = '0;
      wrote_d  = 1'b0;
      err_d    = 1'b0;
    end else if (state_q != IDLE) begin
      if (strobe) begin
        case (state_q)
          CMD: begin
            if (cmd_ok) begin
              ptr_d   = iRx[PTR_W-1:0];
              state_d = DATA;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
          DATA: begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (ptr_q == PTR_W'(i)) shadow_d[i] = iRx;
            end
            wrote_d = 1'b1;
            ptr_d   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
          end
          default: ;
        endcase
      end

      if (cs_rise) begin
        case (state_d)
          DATA: begin
            if (wrote_d) begin
              regs_d = shadow_d;
              upd_d  = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
          DRAIN:   drop = 1'b1;
          default: ;
        endcase
        state_d = IDLE;
      end
    end

    if (drop) begin
      ferr_d = 1'b1;
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= IDLE;
      regs_q     <= {NUM_REGS{RESET_VAL}};
      shadow_q   <= {NUM_REGS{RESET_VAL}};
      ptr_q      <= '0;
      wrote_q    <= 1'b0;
      err_q      <= 1'b0;
      upd_q      <= 1'b0;
      ferr_q     <= 1'b0;
      errcnt_q   <= '0;
      rdy_sync_q <= '0;
      cs_sync_q  <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      shadow_q   <= shadow_d;
      ptr_q      <= ptr_d;
      wrote_q    <= wrote_d;
      err_q      <= err_d;
      upd_q      <= upd_d;
      ferr_q     <= ferr_d;
      errcnt_q   <= errcnt_d;
      rdy_sync_q <= rdy_sync_d;
      cs_sync_q  <= cs_sync_d;
    end
  end

  assign oRegs     = regs_q;
  assign oUpdate   = upd_q;
  assign oFrameErr = ferr_q;
  assign oErrCount = errcnt_q;
  assign probe     = {2'(state_q), wrote_q, err_q, ptr_q};

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: frames of hand-picked bytes, checking registers,
// pulse counts, error counter and debug probe against hand-computed values.
module tb_spi_reg_ctrl;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        iRxReady;
  logic [7:0]  iRx;
  logic        iSPICS;
  logic [31:0] oRegs;
  logic        oUpdate;
  logic        oFrameErr;
  logic [7:0]  oErrCount;
  logic [7:0]  probe;

  int n_vec  = 0;
  int n_miss = 0;
  int upd_cnt  = 0;
  int ferr_cnt = 0;
  int u0, e0;

  spi_reg_ctrl #(.NUM_REGS(4), .RESET_VAL(8'h80)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .iRxReady  (iRxReady),
    .iRx       (iRx),
    .iSPICS    (iSPICS),
    .oRegs     (oRegs),
    .oUpdate   (oUpdate),
    .oFrameErr (oFrameErr),
    .oErrCount (oErrCount),
    .probe     (probe)
  );

  always #5 sysclk = ~sysclk;

  // Pulses last one cycle, so sampling on the falling edge counts each exactly once
  always @(negedge sysclk) begin
    if (oUpdate)   upd_cnt  <= upd_cnt + 1;
    if (oFrameErr) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge sysclk);
    iSPICS = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic cs_high();
    @(negedge sysclk);
    iSPICS = 1'b1;
    repeat (6) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sysclk);
    iRx      = b;
    iRxReady = 1'b1;
    repeat (4) @(negedge sysclk);
    iRxReady = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    repeat (4) @(negedge sysclk);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);
  endtask

  initial begin
    reset    = 1'b1;
    iRxReady = 1'b0;
    iRx      = 8'h00;
    iSPICS   = 1'b1;
    repeat (4) @(negedge sysclk);
    check("rst_regs", 64'(oRegs), 64'h8080_8080);
    check("rst_errcnt", 64'(oErrCount), 64'd0);
    check("rst_upd", 64'(oUpdate), 64'd0);
    check("rst_ferr", 64'(oFrameErr), 64'd0);
    check("rst_state", 64'(probe[7:6]), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge sysclk);

    // Single-byte write to reg1
    u0 = upd_cnt; e0 = ferr_cnt;
    cs_low();
    check("cmd_state", 64'(probe[7:6]), 64'd1);
    send_byte(8'h81);
    check("data_probe", 64'(probe), 64'h81);
    send_byte(8'h40);
    check("data_probe2", 64'(probe), 64'hA2);
    check("no_midframe", 64'(oRegs), 64'h8080_8080);
    cs_high();
    check("w1_regs", 64'(oRegs), 64'h8080_4080);
    check("w1_upd", 64'(upd_cnt - u0), 64'd1);
    check("w1_ferr", 64'(ferr_cnt - e0), 64'd0);

    // Burst starting at reg3 wraps to reg0, reg1
    u0 = upd_cnt;
    cs_low();
    send_byte(8'h83); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cs_high();
    check("burst_regs", 64'(oRegs), 64'h1180_3322);
    check("burst_upd", 64'(upd_cnt - u0), 64'd1);

    // Bad command prefix and out-of-range register
    u0 = upd_cnt; e0 = ferr_cnt;
    cs_low(); send_byte(8'h05); send_byte(8'hAA); cs_high();
    cs_low(); send_byte(8'h84); send_byte(8'hAA); cs_high();
    check("bad_regs", 64'(oRegs), 64'h1180_3322);
    check("bad_ferr", 64'(ferr_cnt - e0), 64'd2);
    check("bad_errcnt", 64'(oErrCount), 64'd2);
    check("bad_upd", 64'(upd_cnt - u0), 64'd0);

    // Command with no data is an error; empty frame is silent
    u0 = upd_cnt; e0 = ferr_cnt;
    cs_low(); send_byte(8'h82); cs_high();
    check("nodata_errcnt", 64'(oErrCount), 64'd3);
    check("nodata_ferr", 64'(ferr_cnt - e0), 64'd1);
    e0 = ferr_cnt;
    cs_low(); cs_high();
    check("empty_ferr", 64'(ferr_cnt - e0), 64'd0);
    check("empty_upd", 64'(upd_cnt - u0), 64'd0);
    check("empty_errcnt", 64'(oErrCount), 64'd3);

    // Last byte's strobe coincides with CS release: byte still commits
    u0 = upd_cnt; e0 = ferr_cnt;
    cs_low();
    send_byte(8'h82);
    @(negedge sysclk);
    iRx = 8'h77; iRxReady = 1'b1; iSPICS = 1'b1;
    repeat (6) @(negedge sysclk);
    iRxReady = 1'b0;
    repeat (4) @(negedge sysclk);
    check("same_cyc_regs", 64'(oRegs), 64'h1177_3322);
    check("same_cyc_upd", 64'(upd_cnt - u0), 64'd1);
    check("same_cyc_ferr", 64'(ferr_cnt - e0), 64'd0);

    // Burst longer than the bank: last write wins
    cs_low();
    send_byte(8'h80);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    cs_high();
    check("wrap_regs", 64'(oRegs), 64'h0403_0205);

    // Reset mid-frame discards everything
    u0 = upd_cnt; e0 = ferr_cnt;
    cs_low(); send_byte(8'h81); send_byte(8'h5A); send_byte(8'h5B);
    do_reset();
    cs_high();
    check("midrst_regs", 64'(oRegs), 64'h8080_8080);
    check("midrst_upd", 64'(upd_cnt - u0), 64'd0);
    check("midrst_ferr", 64'(ferr_cnt - e0), 64'd0);
    check("midrst_errcnt", 64'(oErrCount), 64'd0);

    // CS held low through reset does not open a frame
    @(negedge sysclk);
    iSPICS = 1'b0;
    do_reset();
    u0 = upd_cnt; e0 = ferr_cnt;
    send_byte(8'h80); send_byte(8'h55);
    check("cslow_state", 64'(probe[7:6]), 64'd0);
    cs_high();
    check("cslow_regs", 64'(oRegs), 64'h8080_8080);
    check("cslow_upd", 64'(upd_cnt - u0), 64'd0);
    check("cslow_ferr", 64'(ferr_cnt - e0), 64'd0);
    cs_low(); send_byte(8'h80); send_byte(8'h55); cs_high();
    check("after_toggle", 64'(oRegs), 64'h8080_8055);

    // Error counter saturation
    e0 = ferr_cnt;
    for (int i = 0; i < 255; i++) begin
      cs_low(); send_byte(8'h00); cs_high();
    end
    check("sat_255", 64'(oErrCount), 64'd255);
    cs_low(); send_byte(8'h00); cs_high();
    check("sat_hold", 64'(oErrCount), 64'd255);
    check("sat_pulses", 64'(ferr_cnt - e0), 64'd256);
    check("sat_regs", 64'(oRegs), 64'h8080_8055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
